// File: rtl/bwt_last_column.sv
// -----------------------------------------------------------------------------
// bwt_last_column
//
// Purpose:
//   This module builds the last column of the Burrows-Wheeler transform for a
//   block of N symbols. It captures the original string on a start pulse. A
//   sorter then supplies rotation start offsets in sorted order. For each
//   offset the module emits the symbol that comes just before that rotation,
//   which is buf[(idx+N-1) mod N]. It also records the sorted position of
//   rotation 0 (primary_idx).
//
// Parameters:
//   N      string length / rotations per block (N >= 2)
//   W      symbol width in bits
//   IDX_W  index width, 2**IDX_W >= N
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle pulse in IDLE: capture data_in and begin a block
//   data_in      original string, element 0 is the first symbol
//   idx_valid    sorted rotation index on idx_in is valid
//   idx_in       start offset of the next rotation in sorted order
//   idx_ready    block accepts idx_in this cycle
//   out_valid    out_data holds a last-column symbol
//   out_data     last-column symbol
//   out_last     marks the Nth (final) symbol of the block
//   out_ready    downstream accepts out_data
//   primary_idx  sorted position of rotation 0 (0 if rotation 0 never seen)
//   busy         high in every state except IDLE
//   done         one-cycle pulse when the block completes
//   err          sticky out-of-range index flag
//
// Configuration:
//   BWT_LC_RANGE_CHECK_EN  when defined, an accepted idx_in >= N sets err.
//                          err stays set until the next start or reset.
//                          When undefined, err is tied low.
//   In both builds an out-of-range index emits a zero symbol and still counts.
// -----------------------------------------------------------------------------
module bwt_last_column #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     data_in [0:N-1],
   input  logic             idx_valid,
   input  logic [IDX_W-1:0] idx_in,
   output logic             idx_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [IDX_W-1:0] primary_idx,
   output logic             busy,
   output logic             done,
   output logic             err
);

   // count must reach N, and N fits in IDX_W+1 bits because 2**IDX_W >= N.
   localparam int CNT_W = IDX_W + 1;

   localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(N - 1);
   localparam logic [IDX_W:0]   N_EXT     = (IDX_W + 1)'(N);
   localparam logic [IDX_W-1:0] IDX_WRAP  = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state_reg;
   state_t state_next;

   logic [W-1:0]     sym_buf [0:N-1];
   logic [CNT_W-1:0] count_reg;
   logic [IDX_W-1:0] primary_reg;
   logic             out_valid_reg;
   logic [W-1:0]     out_data_reg;
   logic             out_last_reg;

   logic             capture;
   logic             accept;
   logic             is_final;
   logic             in_range;
   logic [IDX_W-1:0] rot_sel;
   logic [W-1:0]     sym_sel;
   logic             out_fire;

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   assign capture   = (state_reg == IDLE) && start;
   // A new index may enter only when the output register is empty or is
   // being drained in this same cycle. This keeps the one-deep output
   // stage from being overwritten.
   assign idx_ready = (state_reg == STREAM) && (!out_valid_reg || out_ready);
   assign accept    = idx_valid && idx_ready;
   assign is_final  = (count_reg == CNT_FINAL);
   assign out_fire  = out_valid_reg && out_ready;

   // ------------------------------------------------------------------
   // Symbol selection: the last-column symbol is the one that comes just
   // before the rotation start. Offset 0 therefore wraps to N-1.
   // ------------------------------------------------------------------
   assign in_range = ({1'b0, idx_in} < N_EXT);

   always_comb begin
      rot_sel = '0;
      if (idx_in == '0) begin
         rot_sel = IDX_WRAP;
      end else begin
         rot_sel = idx_in - IDX_W'(1);
      end
   end

   // Out-of-range offsets must never address the buffer, so they produce
   // a zero symbol instead.
   always_comb begin
      sym_sel = '0;
      if (in_range) begin
         sym_sel = sym_buf[rot_sel];
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (accept && is_final) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // The final symbol is still in the output register. The block
            // ends only when downstream takes that symbol.
            if (out_fire && out_last_reg) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // String buffer. Its contents are don't-care after reset, so it has
   // no reset and can map onto plain storage.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < N; i++) begin
            sym_buf[i] <= data_in[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Rotation counter and primary index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg   <= '0;
         primary_reg <= '0;
      end else if (capture) begin
         count_reg   <= '0;
         primary_reg <= '0;
      end else if (accept) begin
         count_reg <= count_reg + CNT_W'(1);
         // The sorted position is the count before this increment.
         if (idx_in == '0) begin
            primary_reg <= count_reg[IDX_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Output register. A new accept takes priority over the clear on
   // handshake, which allows one symbol per cycle under full throughput.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= sym_sel;
         out_last_reg  <= is_final;
      end else if (out_fire) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Optional range check
   // ------------------------------------------------------------------
`ifdef BWT_LC_RANGE_CHECK_EN
   logic err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_reg <= 1'b0;
      end else if (capture) begin
         err_reg <= 1'b0;
      end else if (accept && !in_range) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign out_valid   = out_valid_reg;
   assign out_data    = out_data_reg;
   assign out_last    = out_last_reg;
   assign primary_idx = primary_reg;
   assign busy        = (state_reg != IDLE);
   assign done        = (state_reg == DONE);

endmodule
